// File: rtl/and_resp_checker.sv
// Response checker for a two-input AND device: compares both device outputs
// against a & b over NUM_VEC valid vectors and reports counts, coverage and a verdict.
module and_resp_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             out_assign,
  input  logic             out_alwaysblock,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld,
  output logic [3:0]       cov
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  logic [1:0]       state;
  logic             pass_q;
  logic             exp_res;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       cov_nxt;

  // err_nxt/cov_nxt include the vector being sampled so the verdict counts the last one
  always_comb begin
    exp_res  = a & b;
    mismatch = (out_assign != exp_res) || (out_alwaysblock != exp_res);
    err_nxt  = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_nxt = err_cnt + CNT_W'(1);
    end
    cov_nxt  = cov | (4'b0001 << {a, b});
    last_vec = (vec_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pass_q        <= 1'b0;
      err_cnt       <= '0;
      vec_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      cov           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            pass_q        <= 1'b0;
            err_cnt       <= '0;
            vec_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            cov           <= '0;
          end
        end
        RUN: begin
          if (valid) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
            cov     <= cov_nxt;
            err_cnt <= err_nxt;
            if (mismatch && !first_err_vld) begin
              first_err_idx <= vec_cnt;
              first_err_vld <= 1'b1;
            end
            if (last_vec) begin
              state  <= DONE;
              pass_q <= (err_nxt == '0) && (cov_nxt == 4'b1111);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = pass_q;

endmodule

// File: doc/and_resp_checker.md
AND_RESP_CHECKER -- requirements
Module: and_resp_checker

Interface
REQ-001 Parameter NUM_VEC, default 4, SHALL set the number of valid response vectors per check run (legal 1..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the vector and error counters.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1, SHALL request a new check run; single-cycle pulse.
REQ-006 Port valid, input, 1, SHALL qualify a, b, out_assign and out_alwaysblock for sampling in the current cycle.
REQ-007 Port a, input, 1, SHALL carry the stimulus operand a applied to the device under check.
REQ-008 Port b, input, 1, SHALL carry the stimulus operand b applied to the device under check.
REQ-009 Port out_assign, input, 1, SHALL carry the device's continuous-assignment AND result.
REQ-010 Port out_alwaysblock, input, 1, SHALL carry the device's procedural-block AND result.
REQ-011 Port busy, output, 1, SHALL be high while a run is in progress.
REQ-012 Port done, output, 1, SHALL be high while a completed run's results are held.
REQ-013 Port pass, output, 1, SHALL be the run verdict; meaningful only while done=1.
REQ-014 Port err_cnt, output, CNT_W, SHALL count mismatching vectors in the current or last run.
REQ-015 Port vec_cnt, output, CNT_W, SHALL count valid vectors sampled in the current or last run.
REQ-016 Port first_err_idx, output, CNT_W, SHALL give the vec_cnt value of the first mismatching vector.
REQ-017 Port first_err_vld, output, 1, SHALL be high once first_err_idx holds a captured index.
REQ-018 Port cov, output, 4, SHALL be the coverage mask; bit {a,b} is set once that input pair has been sampled.

Function
REQ-019 The block SHALL use a three-state FSM: IDLE, RUN and DONE.
REQ-020 IDLE: busy=0, done=0, pass=0.
REQ-021 IDLE with start=1 SHALL go to RUN on the next edge and clear err_cnt, vec_cnt, first_err_idx, first_err_vld and cov.
REQ-022 DONE with start=1 SHALL go to RUN on the next edge with the same clearing; start in RUN SHALL be ignored.
REQ-023 valid SHALL be ignored outside RUN, including during the start cycle.
REQ-024 RUN with valid=1: expected result exp = a & b.
REQ-025 A vector SHALL mismatch when out_assign != exp or out_alwaysblock != exp.
REQ-026 A mismatching vector SHALL increment err_cnt by 1, saturating at all-ones.
REQ-027 On the first mismatch of a run, first_err_idx SHALL take the pre-increment vec_cnt and first_err_vld SHALL be set; later mismatches SHALL not change either.
REQ-028 Each valid vector in RUN SHALL set cov[{a,b}] and increment vec_cnt.
REQ-029 A valid vector sampled when vec_cnt == NUM_VEC-1 SHALL be the last one: the FSM goes to DONE on that edge and vec_cnt ends at NUM_VEC.
REQ-030 pass, registered on entry to DONE, SHALL equal (final err_cnt == 0) AND (final cov == 4'b1111), counting the last vector.
REQ-031 DONE SHALL drive done=1 and busy=0 and hold all counters, cov and pass until the next start.
REQ-032 RUN SHALL drive busy=1 and done=0.
REQ-033 Latency: done SHALL rise on the edge that samples the last valid vector; there are no other pipeline stages.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for clk, force IDLE and drive all outputs and counters to 0.
REQ-035 Reset asserted during RUN SHALL abort the run and discard partial results.
REQ-036 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-037 Scenario: start, then correct responses for (a,b) = 00, 01, 10, 11 -> done=1, pass=1, err_cnt=0, vec_cnt=4, cov=4'b1111, first_err_vld=0.
REQ-038 Scenario: as REQ-037, but out_alwaysblock=0 on vector 11 -> pass=0, err_cnt=1, first_err_idx=3, first_err_vld=1.
REQ-039 Scenario: four correct vectors, all (a,b)=11 -> pass=0, err_cnt=0, cov=4'b1000.
REQ-040 Scenario: valid gaps between vectors, plus valid pulses while in IDLE and in DONE -> only valid vectors in RUN are counted; vec_cnt=4.
REQ-041 Scenario: rst_n pulsed low mid-run after 2 vectors -> outputs 0 immediately; a new start and 4 good vectors -> pass=1.
REQ-042 Scenario: NUM_VEC=255 with every vector wrong -> err_cnt=255, pass=0; then start in DONE -> all counters clear and a new run begins.
